// File: rtl/lenet_sched.sv
// Layer scheduler: per image load -> conv -> fc1 -> fc2, with a phase watchdog and done-order checking.
// Outputs registered, 1 cycle after the triggering input; pulse handshakes only, no backpressure.
// LENET_SCHED_PERF_EN adds the perf_cycles / perf_last cycle counters.
module lenet_sched #(
  parameter int                   IMG_CNT_W   = 8,
  parameter int                   TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 20'hFFFFF
) (
  input  logic                 clk,
  input  logic                 srstn,
  input  logic                 start,
  input  logic [IMG_CNT_W-1:0] num_images,
  output logic                 load_req,
  input  logic                 load_ack,
  output logic                 conv_start,
  input  logic                 conv_done,
  input  logic                 fc1_done,
  input  logic                 fc2_done,
  output logic                 fc_done,
  output logic                 img_valid,
  output logic [IMG_CNT_W-1:0] img_idx,
  output logic                 busy,
  output logic                 batch_done,
  output logic                 err,
  output logic [1:0]           err_code
`ifdef LENET_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_last
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_CONV, S_FC1, S_FC2, S_NEXT, S_ERR
  } state_t;

  localparam logic [IMG_CNT_W-1:0] IDX_ONE  = IMG_CNT_W'(1);
  localparam logic [TIMEOUT_W-1:0] WD_ONE   = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_MAX - WD_ONE;
  localparam logic [1:0]           EC_NONE  = 2'b00;
  localparam logic [1:0]           EC_TMO   = 2'b01;
  localparam logic [1:0]           EC_ORDER = 2'b10;

  state_t               state, state_nxt;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [IMG_CNT_W-1:0] last_idx;
  logic                 wd_hit, any_done;
  logic                 start_acc, order_err, timeout;
  logic                 img_fin, batch_fin;
  logic                 load_req_nxt, conv_start_nxt, busy_nxt, err_nxt;
  logic [1:0]           err_code_nxt;
  logic [IMG_CNT_W-1:0] img_idx_nxt;

  assign wd_hit   = (wd_cnt == WD_LAST);
  assign any_done = conv_done | fc1_done | fc2_done;

  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) begin
      state      <= S_IDLE;
      wd_cnt     <= '0;
      last_idx   <= '0;
      load_req   <= 1'b0;
      conv_start <= 1'b0;
      fc_done    <= 1'b0;
      img_valid  <= 1'b0;
      img_idx    <= '0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= EC_NONE;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wd_cnt <= '0;
      else if (state inside {S_LOAD, S_CONV, S_FC1, S_FC2})
        wd_cnt <= wd_cnt + WD_ONE;
      // A zero-length batch runs a single image.
      if (start_acc)
        last_idx <= (num_images == '0) ? '0 : num_images - IDX_ONE;
      load_req   <= load_req_nxt;
      conv_start <= conv_start_nxt;
      fc_done    <= img_fin;
      img_valid  <= img_fin;
      img_idx    <= img_idx_nxt;
      busy       <= busy_nxt;
      batch_done <= batch_fin;
      err        <= err_nxt;
      err_code   <= err_code_nxt;
    end
  end

  // Unexpected dones take priority over the expected one; any done beats a same-cycle expiry.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    order_err = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        order_err = any_done;
        if (load_ack) state_nxt = S_KICK;
        else          timeout   = wd_hit;
      end
      S_KICK: begin
        order_err = any_done;
        state_nxt = S_CONV;
      end
      S_CONV: begin
        order_err = fc1_done | fc2_done;
        if (conv_done) state_nxt = S_FC1;
        else           timeout   = wd_hit;
      end
      S_FC1: begin
        order_err = conv_done | fc2_done;
        if (fc1_done) state_nxt = S_FC2;
        else          timeout   = wd_hit;
      end
      S_FC2: begin
        order_err = conv_done | fc1_done;
        if (fc2_done) state_nxt = S_NEXT;
        else          timeout   = wd_hit;
      end
      S_NEXT: begin
        order_err = any_done;
        state_nxt = (img_idx == last_idx) ? S_IDLE : S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (order_err || timeout)
      state_nxt = S_ERR;
  end

  always_comb begin
    load_req_nxt   = (state_nxt == S_LOAD);
    conv_start_nxt = (state_nxt == S_KICK);
    busy_nxt       = (state_nxt != S_IDLE);
    img_fin        = (state == S_FC2) && (state_nxt == S_NEXT);
    batch_fin      = (state == S_NEXT) && (state_nxt == S_IDLE);
    img_idx_nxt    = img_idx;
    err_nxt        = err;
    err_code_nxt   = err_code;
    if (start_acc) begin
      img_idx_nxt  = '0;
      err_nxt      = 1'b0;
      err_code_nxt = EC_NONE;
    end else if ((state == S_NEXT) && (state_nxt == S_LOAD)) begin
      img_idx_nxt = img_idx + IDX_ONE;
    end
    if (order_err) begin
      err_nxt      = 1'b1;
      err_code_nxt = EC_ORDER;
    end else if (timeout) begin
      err_nxt      = 1'b1;
      err_code_nxt = EC_TMO;
    end
  end

`ifdef LENET_SCHED_PERF_EN
  logic [31:0] img_cyc;
  logic        running;

  assign running = (state != S_IDLE) && (state != S_ERR);

  // img_cyc restarts on every LOAD entry so perf_last covers one image, LOAD through FC2.
  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) begin
      perf_cycles <= '0;
      perf_last   <= '0;
      img_cyc     <= '0;
    end else begin
      if (start_acc)
        perf_cycles <= '0;
      else if (running && (perf_cycles != '1))
        perf_cycles <= perf_cycles + 32'd1;
      if ((state_nxt == S_LOAD) && (state != S_LOAD))
        img_cyc <= '0;
      else if (running && (img_cyc != '1))
        img_cyc <= img_cyc + 32'd1;
      if (img_fin)
        perf_last <= (img_cyc == '1) ? img_cyc : img_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lenet_sched.sv
// Directed bench for lenet_sched: table of single-cycle vectors plus hand sequences
// for watchdog, order errors and mid-batch reset. Watchdog shortened to 16 cycles.
module tb_lenet_sched;

  logic       clk = 1'b0;
  logic       srstn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_images = 8'd0;
  logic       load_ack = 1'b0, conv_done = 1'b0, fc1_done = 1'b0, fc2_done = 1'b0;
  logic       load_req, conv_start, fc_done, img_valid, busy, batch_done, err;
  logic [7:0] img_idx;
  logic [1:0] err_code;
  logic [16:0] outs;

  always #5 clk = ~clk;

  lenet_sched #(.IMG_CNT_W(8), .TIMEOUT_W(20), .TIMEOUT_MAX(20'd16)) dut (
    .clk(clk), .srstn(srstn), .start(start), .num_images(num_images),
    .load_req(load_req), .load_ack(load_ack), .conv_start(conv_start),
    .conv_done(conv_done), .fc1_done(fc1_done), .fc2_done(fc2_done),
    .fc_done(fc_done), .img_valid(img_valid), .img_idx(img_idx), .busy(busy),
    .batch_done(batch_done), .err(err), .err_code(err_code)
  );

  assign outs = {load_req, conv_start, fc_done, img_valid, busy, batch_done, err, err_code, img_idx};

  localparam logic [3:0] E_NONE = 4'b0000, E_ACK = 4'b1000, E_CD = 4'b0100,
                         E_F1 = 4'b0010, E_F2 = 4'b0001;
  localparam logic [1:0] EC_TMO = 2'b01, EC_ORD = 2'b10;

  typedef struct {
    int          gap;
    logic        st;
    logic [7:0]  num;
    logic [3:0]  ev;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[64];
  int   n_tbl = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [16:0] o(input logic lr, cs, fd, iv, bz, bd, er,
                                    input logic [1:0] ec, input logic [7:0] idx);
    return {lr, cs, fd, iv, bz, bd, er, ec, idx};
  endfunction
  function automatic logic [16:0] x_load(input logic [7:0] i); return o(1,0,0,0,1,0,0,2'b00,i); endfunction
  function automatic logic [16:0] x_kick(input logic [7:0] i); return o(0,1,0,0,1,0,0,2'b00,i); endfunction
  function automatic logic [16:0] x_wait(input logic [7:0] i); return o(0,0,0,0,1,0,0,2'b00,i); endfunction
  function automatic logic [16:0] x_next(input logic [7:0] i); return o(0,0,1,1,1,0,0,2'b00,i); endfunction
  function automatic logic [16:0] x_done(input logic [7:0] i); return o(0,0,0,0,0,1,0,2'b00,i); endfunction
  function automatic logic [16:0] x_idle(input logic [7:0] i); return o(0,0,0,0,0,0,0,2'b00,i); endfunction
  function automatic logic [16:0] x_err(input logic [1:0] c, input logic [7:0] i);
    return o(0,0,0,0,1,0,1,c,i);
  endfunction

  task automatic add(input int gap, input logic st, input logic [7:0] num,
                     input logic [3:0] ev, input logic [16:0] exp);
    tbl[n_tbl].gap = gap;
    tbl[n_tbl].st  = st;
    tbl[n_tbl].num = num;
    tbl[n_tbl].ev  = ev;
    tbl[n_tbl].exp = exp;
    n_tbl++;
  endtask

  task automatic check(input string nm, input logic [16:0] got, input logic [16:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gap quiet cycles, then one cycle with the given inputs, then compare all outputs.
  task automatic apply(input string nm, input int gap, input logic st, input logic [7:0] num,
                       input logic [3:0] ev, input logic [16:0] exp);
    repeat (gap) step();
    start = st;
    num_images = num;
    {load_ack, conv_done, fc1_done, fc2_done} = ev;
    step();
    start = 1'b0;
    {load_ack, conv_done, fc1_done, fc2_done} = 4'b0000;
    check(nm, outs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // single image, with start ignored mid-batch and a done ignored in IDLE
    add(0, 1, 8'd1, E_NONE, x_load(0));
    add(3, 0, 8'd1, E_ACK,  x_kick(0));
    add(0, 0, 8'd1, E_NONE, x_wait(0));
    add(4, 1, 8'd5, E_NONE, x_wait(0));
    add(9, 0, 8'd1, E_CD,   x_wait(0));
    add(8, 0, 8'd1, E_F1,   x_wait(0));
    add(5, 0, 8'd1, E_F2,   x_next(0));
    add(0, 0, 8'd1, E_NONE, x_done(0));
    add(2, 0, 8'd1, E_CD,   x_idle(0));
    // num_images = 0 runs one image
    add(0, 1, 8'd0, E_NONE, x_load(0));
    add(1, 0, 8'd0, E_ACK,  x_kick(0));
    add(2, 0, 8'd0, E_CD,   x_wait(0));
    add(1, 0, 8'd0, E_F1,   x_wait(0));
    add(1, 0, 8'd0, E_F2,   x_next(0));
    add(0, 0, 8'd0, E_NONE, x_done(0));
    // batch of 3
    add(0, 1, 8'd3, E_NONE, x_load(0));
    for (int i = 0; i < 3; i++) begin
      add(2, 0, 8'd3, E_ACK, x_kick(8'(i)));
      add(1, 0, 8'd3, E_CD,  x_wait(8'(i)));
      add(2, 0, 8'd3, E_F1,  x_wait(8'(i)));
      add(3, 0, 8'd3, E_F2,  x_next(8'(i)));
      if (i < 2) add(0, 0, 8'd3, E_NONE, x_load(8'(i + 1)));
      else       add(0, 0, 8'd3, E_NONE, x_done(8'd2));
    end
    add(0, 0, 8'd3, E_NONE, x_idle(8'd2));

    repeat (3) @(posedge clk);
    #1;
    check("reset_held", outs, 17'd0);
    srstn = 1'b0;
    step();
    check("reset_release", outs, 17'd0);

    for (int i = 0; i < n_tbl; i++)
      apply($sformatf("vec%0d", i), tbl[i].gap, tbl[i].st, tbl[i].num, tbl[i].ev, tbl[i].exp);

    // watchdog expiry on the second image of a 2-image batch
    apply("to_start", 0, 1, 8'd2, E_NONE, x_load(0));
    apply("to_ack0",  1, 0, 8'd2, E_ACK,  x_kick(0));
    apply("to_cd0",   1, 0, 8'd2, E_CD,   x_wait(0));
    apply("to_f10",   0, 0, 8'd2, E_F1,   x_wait(0));
    apply("to_f20",   0, 0, 8'd2, E_F2,   x_next(0));
    apply("to_load1", 0, 0, 8'd2, E_NONE, x_load(1));
    apply("to_ack1",  0, 0, 8'd2, E_ACK,  x_kick(1));
    apply("to_conv1", 0, 0, 8'd2, E_NONE, x_wait(1));
    apply("wd_15",   14, 0, 8'd2, E_NONE, x_wait(1));
    apply("wd_16",    0, 0, 8'd2, E_NONE, x_err(EC_TMO, 1));
    apply("err_hold", 3, 0, 8'd2, E_CD,   x_err(EC_TMO, 1));
    apply("err_restart", 2, 1, 8'd1, E_NONE, x_load(0));
    // done on the expiry cycle wins; counter restarts in FC1
    apply("dw_ack",   0, 0, 8'd1, E_ACK,  x_kick(0));
    apply("dw_conv",  0, 0, 8'd1, E_NONE, x_wait(0));
    apply("dw_tie",  15, 0, 8'd1, E_CD,   x_wait(0));
    apply("dw_fc1",  15, 0, 8'd1, E_F1,   x_wait(0));
    apply("dw_fc2",   1, 0, 8'd1, E_F2,   x_next(0));
    apply("dw_done",  0, 0, 8'd1, E_NONE, x_done(0));

    // out-of-order dones
    apply("oe_start",  0, 1, 8'd1, E_NONE, x_load(0));
    apply("oe_ack",    0, 0, 8'd1, E_ACK,  x_kick(0));
    apply("oe_f2_conv", 2, 0, 8'd1, E_F2,  x_err(EC_ORD, 0));
    apply("oe_no_fcdone", 1, 0, 8'd1, E_NONE, x_err(EC_ORD, 0));
    apply("oe_start2", 0, 1, 8'd1, E_NONE, x_load(0));
    apply("oe_ack2",   0, 0, 8'd1, E_ACK,  x_kick(0));
    apply("oe_cd_f1",  1, 0, 8'd1, E_CD | E_F1, x_err(EC_ORD, 0));
    apply("oe_start3", 0, 1, 8'd1, E_NONE, x_load(0));
    apply("oe_ack3",   0, 0, 8'd1, E_ACK,  x_kick(0));
    apply("oe_cd3",    1, 0, 8'd1, E_CD,   x_wait(0));
    apply("oe_f13",    0, 0, 8'd1, E_F1,   x_wait(0));
    apply("oe_f2_cd",  2, 0, 8'd1, E_F2 | E_CD, x_err(EC_ORD, 0));
    apply("oe_start4", 0, 1, 8'd1, E_NONE, x_load(0));
    apply("oe_cd_load", 1, 0, 8'd1, E_CD,  x_err(EC_ORD, 0));

    // reset in FC1, then a clean batch
    apply("rs_start", 0, 1, 8'd2, E_NONE, x_load(0));
    apply("rs_ack",   0, 0, 8'd2, E_ACK,  x_kick(0));
    apply("rs_cd",    1, 0, 8'd2, E_CD,   x_wait(0));
    srstn = 1'b1;
    #2;
    check("rs_async", outs, 17'd0);
    step();
    srstn = 1'b0;
    check("rs_hold", outs, 17'd0);
    apply("rs_idle_f1", 1, 0, 8'd2, E_F1,  x_idle(0));
    apply("rc_start", 0, 1, 8'd1, E_NONE, x_load(0));
    apply("rc_ack",   2, 0, 8'd1, E_ACK,  x_kick(0));
    apply("rc_cd",    3, 0, 8'd1, E_CD,   x_wait(0));
    apply("rc_f1",    2, 0, 8'd1, E_F1,   x_wait(0));
    apply("rc_f2",    2, 0, 8'd1, E_F2,   x_next(0));
    apply("rc_done",  0, 0, 8'd1, E_NONE, x_done(0));
    apply("rc_idle",  0, 0, 8'd1, E_NONE, x_idle(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lenet_sched.md
Name: lenet_sched

Overview:
Top-level layer scheduler for the lenet accelerator. It batches N images through the core, one after another. For each image it runs a host load handshake into SRAM_a, then pulses conv_start. It then waits for conv_done, fc1_done and fc2_done in order, and feeds fc2 completion back to the conv engine as fc_done. It also guards every phase with a watchdog and reports per-image completion to the host.

Parameters:
IMG_CNT_W, 8, width of the image-count and image-index fields
TIMEOUT_W, 20, width of the watchdog counter
TIMEOUT_MAX, 20'hFFFFF, cycles allowed in any waiting state before the error trap

Ports:
clk  in  1  system clock
srstn  in  1  asynchronous, active-high reset (asserted = 1)
start  in  1  one-cycle pulse; starts a batch when in IDLE
num_images  in  IMG_CNT_W  images in the batch; sampled on start; 0 is treated as 1
load_req  out  1  request to host to load the next image into SRAM_a
load_ack  in  1  host reports that the image is resident in SRAM_a
conv_start  out  1  one-cycle pulse to the conv engine
conv_done  in  1  conv engine completion pulse
fc1_done  in  1  fc layer-1 completion pulse
fc2_done  in  1  fc layer-2 completion pulse (result written to SRAM_f)
fc_done  out  1  one-cycle pulse back to the conv engine, echoes accepted fc2_done
img_valid  out  1  one-cycle pulse; the result of image img_idx is ready
img_idx  out  IMG_CNT_W  index of the current image, starting at 0
busy  out  1  high in any state other than IDLE
batch_done  out  1  one-cycle pulse when the last image completes
err  out  1  sticky watchdog/protocol error; cleared only by reset or by start
err_code  out  2  01 = timeout, 10 = out-of-order done, 00 = none

Behaviour:
- Reset (srstn=1, asynchronous): state=IDLE; all outputs 0; all counters 0.
- States: IDLE, LOAD, KICK, CONV, FC1, FC2, NEXT, ERR.
- IDLE:
  - start=1 latches num_images (0→1), clears img_idx, err and err_code, then goes to LOAD.
  - start is ignored in every other state.
- LOAD: load_req=1 (registered, asserted the cycle after entry). On load_ack=1, load_req drops the next cycle and the state goes to KICK.
- KICK: conv_start=1 for exactly one cycle, then CONV.
- CONV: wait for conv_done, then FC1.
- FC1: wait for fc1_done, then FC2.
- FC2: on fc2_done:
  - fc_done=1 and img_valid=1 next cycle for one cycle, with img_idx still holding the finished image's index;
  - go to NEXT.
- NEXT (one cycle):
  - if img_idx == latched count − 1: batch_done=1 for one cycle, then IDLE;
  - otherwise img_idx+1 and LOAD.
- Watchdog:
  - clears on every state change;
  - increments each cycle in LOAD, CONV, FC1 and FC2;
  - reaching TIMEOUT_MAX sends the block to ERR with err=1 and err_code=01.
- Out-of-order done:
  - a done pulse not expected in the current state (e.g. fc1_done in CONV, conv_done in FC2) goes to ERR with err_code=10;
  - done pulses are ignored while in IDLE.
- Same-cycle events:
  - if the expected done and an unexpected done arrive together, the error wins;
  - if a done arrives in the same cycle as the watchdog expiry, the done wins.
- ERR: busy=1, all pulses suppressed. Only reset or start leaves ERR; start behaves as from IDLE.
- Every output is registered. Latency from an input event to the corresponding output pulse is exactly 1 cycle.
- Reset mid-batch returns immediately to IDLE with outputs 0; there is no resume.

Optional Feature:
Macro LENET_SCHED_PERF_EN.
- Defined:
  - adds output perf_cycles [31:0], which counts cycles while busy=1 and not in ERR;
  - the counter is cleared on start, saturates at 32'hFFFFFFFF and holds its value after batch_done;
  - adds output perf_last [31:0], which holds the cycle count of the most recently completed image, updated on img_valid.
- Undefined: neither port nor counter exists.

Test Plan:
- Single image: start with num_images=1; ack 3 cycles after load_req; conv_done@+100, fc1_done@+50, fc2_done@+20 → one conv_start, fc_done and img_valid with img_idx=0, batch_done the cycle after NEXT, busy returns to 0.
- Batch of 3 → load_req is asserted 3 times; img_valid fires with img_idx 0, 1, 2; batch_done fires once, after idx 2.
- num_images=0 → behaves exactly like the 1-image case.
- Timeout: TIMEOUT_MAX=16 (overridden); never send conv_done → err=1 and err_code=01 exactly 16 cycles after CONV entry; busy stays 1; a subsequent start clears err and restarts at img_idx=0.
- Order error: fc2_done during CONV → err_code=10, no fc_done; same-cycle conv_done+fc1_done in CONV → ERR.
- Reset mid-FC1 (srstn=1 for 1 cycle) → all outputs 0 and the block in IDLE; a later start runs a clean batch.
